// File: rtl/tx_port_arbiter.sv
// Purpose : round-robin arbiter sharing one 2-phase tx channel among N requesters;
//           data is registered and forwarded, the downstream ack goes back to the granted lane only.
// Latency : grant one edge after in_req toggles; in_ack one edge after out_ack matches out_req.
// Backpressure: one transfer in flight; other lanes stay pending (in_req ^ in_ack) until served.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_req / in_ack      per-lane 2-phase request / acknowledge toggles
//   in_data              lane i data in bits [i*SIZE +: SIZE]
//   out_req / out_ack    2-phase handshake to the tx transceiver
//   out_data             registered data of the current/last transfer
//   grant_id             current or last granted lane
//   busy                 transfer outstanding (WAIT_ACK)
//   xfer_count           completed transfers, wraps at 16 bits
`ifndef SIZE
`define SIZE 8
`endif

module tx_port_arbiter #(
  parameter int id = -1,
  parameter int N  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_req,
  output logic [N-1:0]         in_ack,
  input  logic [N*`SIZE-1:0]   in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [`SIZE-1:0]     out_data,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          xfer_count
);

  localparam int SZ = `SIZE;

  if (N < 1 || N > 8 || id < -1) begin : g_param_check
    $error("tx_port_arbiter: N must be in 1..8 and id >= -1");
  end

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t          state, state_d;
  logic [2:0]      last, last_d;
  logic [2:0]      grant_id_d;
  logic [2:0]      pick;
  logic            found;
  logic [N-1:0]    pending;
  logic [N-1:0]    in_ack_d;
  logic            out_req_d;
  logic [SZ-1:0]   out_data_d;
  logic [15:0]     xfer_count_d;

  assign pending = in_req ^ in_ack;
  assign busy    = (state == WAIT_ACK);

  // Rotating priority: a lane's rank is its distance past the last served lane,
  // so the lane just served ranks lowest (N-1) and last+1 ranks highest (0).
  always_comb begin
    int best;
    int off;
    found = 1'b0;
    pick  = last;
    best  = N;
    off   = 0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        off = (i + 2 * N - int'(last) - 1) % N;
        if (off < best) begin
          best  = off;
          pick  = 3'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state;
    last_d       = last;
    grant_id_d   = grant_id;
    in_ack_d     = in_ack;
    out_req_d    = out_req;
    out_data_d   = out_data;
    xfer_count_d = xfer_count;
    case (state)
      IDLE: begin
        if (found) begin
          out_req_d  = ~out_req;
          grant_id_d = pick;
          state_d    = WAIT_ACK;
          for (int i = 0; i < N; i++) begin
            if (pick == 3'(i)) out_data_d = in_data[i*SZ +: SZ];
          end
        end
      end
      WAIT_ACK: begin
        // 2-phase: the transceiver has answered once its toggle catches up with ours.
        if (out_ack == out_req) begin
          for (int i = 0; i < N; i++) begin
            if (grant_id == 3'(i)) in_ack_d[i] = ~in_ack[i];
          end
          last_d       = grant_id;
          xfer_count_d = xfer_count + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 3'(N - 1);
      grant_id   <= 3'(N - 1);
      in_ack     <= '0;
      out_req    <= 1'b0;
      out_data   <= '0;
      xfer_count <= '0;
    end else begin
      state      <= state_d;
      last       <= last_d;
      grant_id   <= grant_id_d;
      in_ack     <= in_ack_d;
      out_req    <= out_req_d;
      out_data   <= out_data_d;
      xfer_count <= xfer_count_d;
    end
  end

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Bench for tx_port_arbiter (N=5, 8-bit data): scoreboard of expected grants,
// checked whenever out_req toggles, plus per-scenario tasks.
module tb_tx_port_arbiter;

  localparam int N  = 5;
  localparam int SZ = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req;
  logic [N-1:0]    in_ack;
  logic [N*SZ-1:0] in_data;
  logic            out_req;
  logic            out_ack;
  logic [SZ-1:0]   out_data;
  logic [2:0]      grant_id;
  logic            busy;
  logic [15:0]     xfer_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]    gid;
    logic [SZ-1:0] dat;
  } exp_t;

  exp_t sb[$];
  logic prev_req = 1'b0;

  tx_port_arbiter #(.id(0), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_req     (in_req),
    .in_ack     (in_ack),
    .in_data    (in_data),
    .out_req    (out_req),
    .out_ack    (out_ack),
    .out_data   (out_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge, sample 1 time unit later, score any new grant,
  // and optionally answer out_req immediately (ack seen at the next edge).
  task automatic cycle(input bit auto_ack);
    exp_t e;
    @(posedge clk);
    #1;
    if (out_req !== prev_req) begin
      prev_req = out_req;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_grant: grant_id=%0d out_data=%02h, none expected", grant_id, out_data);
      end else begin
        e = sb.pop_front();
        if (grant_id !== e.gid) begin
          fails++;
          $display("FAIL grant_order: got grant_id=%0d, expected %0d", grant_id, e.gid);
        end
        tests++;
        if (out_data !== e.dat) begin
          fails++;
          $display("FAIL grant_data: got out_data=%02h, expected %02h", out_data, e.dat);
        end
      end
    end
    if (auto_ack) out_ack = out_req;
  endtask

  task automatic expect_lane(input int lane, input logic [SZ-1:0] d);
    exp_t e;
    in_data[lane*SZ +: SZ] = d;
    e.gid = 3'(lane);
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic wait_xfer(input logic [15:0] target, input int budget, input bit auto_ack);
    int n = 0;
    while (xfer_count !== target && n < budget) begin
      cycle(auto_ack);
      n++;
    end
    tests++;
    if (xfer_count !== target) begin
      fails++;
      $display("FAIL wait_xfer_timeout: xfer_count=%04h, expected %04h within %0d cycles", xfer_count, target, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    in_req  = '0;
    out_ack = 1'b0;
    in_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    prev_req = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_values(input string tag);
    tests++; if (out_req !== 1'b0)       begin fails++; $display("FAIL %s_out_req: got %b, expected 0", tag, out_req); end
    tests++; if (in_ack !== 5'b0)        begin fails++; $display("FAIL %s_in_ack: got %b, expected 00000", tag, in_ack); end
    tests++; if (out_data !== 8'h00)     begin fails++; $display("FAIL %s_out_data: got %02h, expected 00", tag, out_data); end
    tests++; if (grant_id !== 3'd4)      begin fails++; $display("FAIL %s_grant_id: got %0d, expected 4", tag, grant_id); end
    tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL %s_busy: got %b, expected 0", tag, busy); end
    tests++; if (xfer_count !== 16'h0)   begin fails++; $display("FAIL %s_xfer_count: got %04h, expected 0000", tag, xfer_count); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_reset_values("reset");
  endtask

  task automatic test_single();
    expect_lane(2, 8'h5A);
    in_req[2] = ~in_req[2];
    cycle(1'b0);
    tests++; if (out_req !== 1'b1)   begin fails++; $display("FAIL single_out_req: got %b, expected 1", out_req); end
    tests++; if (out_data !== 8'h5A) begin fails++; $display("FAIL single_out_data: got %02h, expected 5a", out_data); end
    tests++; if (grant_id !== 3'd2)  begin fails++; $display("FAIL single_grant_id: got %0d, expected 2", grant_id); end
    tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL single_busy: got %b, expected 1", busy); end
    out_ack = ~out_ack;
    cycle(1'b0);
    tests++; if (in_ack !== 5'b00100)    begin fails++; $display("FAIL single_in_ack: got %b, expected 00100", in_ack); end
    tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL single_busy_done: got %b, expected 0", busy); end
    tests++; if (xfer_count !== 16'd1)   begin fails++; $display("FAIL single_xfer_count: got %0d, expected 1", xfer_count); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) expect_lane(i, 8'(8'h10 + i));
    in_req = ~in_req;
    wait_xfer(16'd5, 40, 1'b1);
    tests++; if (in_ack !== 5'b11111) begin fails++; $display("FAIL rr_in_ack: got %b, expected 11111", in_ack); end
    tests++; if (sb.size() != 0)      begin fails++; $display("FAIL rr_pending_grants: got %0d left, expected 0", sb.size()); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rr_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_fairness();
    expect_lane(3, 8'h33);
    in_req[3] = ~in_req[3];
    wait_xfer(16'd6, 10, 1'b1);
    expect_lane(4, 8'h44);
    expect_lane(1, 8'h11);
    in_req[1] = ~in_req[1];
    in_req[4] = ~in_req[4];
    wait_xfer(16'd8, 20, 1'b1);
    tests++; if (grant_id !== 3'd1) begin fails++; $display("FAIL fair_last_grant: got %0d, expected 1", grant_id); end
    tests++; if (sb.size() != 0)    begin fails++; $display("FAIL fair_pending_grants: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_stall();
    logic       r;
    logic [N-1:0] a;
    expect_lane(0, 8'hA0);
    expect_lane(1, 8'hB1);
    in_req[0] = ~in_req[0];
    in_req[1] = ~in_req[1];
    cycle(1'b0);
    r = out_req;
    a = in_ack;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0);
      tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL stall_busy[%0d]: got %b, expected 1", c, busy); end
      tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL stall_grant[%0d]: got %0d, expected 0", c, grant_id); end
      tests++; if (out_req !== r)     begin fails++; $display("FAIL stall_out_req[%0d]: got %b, expected %b", c, out_req, r); end
      tests++; if (in_ack !== a)      begin fails++; $display("FAIL stall_in_ack[%0d]: got %b, expected %b", c, in_ack, a); end
    end
    out_ack = out_req;
    cycle(1'b0);
    tests++; if (in_ack !== (a ^ 5'b00001)) begin fails++; $display("FAIL stall_ack_lane0: got %b, expected %b", in_ack, a ^ 5'b00001); end
    tests++; if (busy !== 1'b0)             begin fails++; $display("FAIL stall_idle_gap: got busy=%b, expected 0", busy); end
    cycle(1'b0);
    tests++; if (grant_id !== 3'd1) begin fails++; $display("FAIL stall_next_grant: got %0d, expected 1", grant_id); end
    tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL stall_next_busy: got %b, expected 1", busy); end
    out_ack = out_req;
    cycle(1'b0);
    tests++; if (xfer_count !== 16'd10) begin fails++; $display("FAIL stall_xfer_count: got %0d, expected 10", xfer_count); end
  endtask

  task automatic test_reset_mid();
    expect_lane(2, 8'h77);
    in_req[2] = ~in_req[2];
    cycle(1'b0);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b, expected 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    in_req   = '0;
    out_ack  = 1'b0;
    prev_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) cycle(1'b0);
    tests++; if (out_req !== 1'b0) begin fails++; $display("FAIL midrst_out_req_after: got %b, expected 0", out_req); end
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL midrst_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_wrap();
    force dut.xfer_count = 16'hFFFF;
    cycle(1'b0);
    release dut.xfer_count;
    #1;
    tests++; if (xfer_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %04h, expected ffff", xfer_count); end
    expect_lane(0, 8'h5C);
    in_req[0] = ~in_req[0];
    wait_xfer(16'h0000, 10, 1'b1);
    tests++; if (in_ack !== 5'b00001) begin fails++; $display("FAIL wrap_in_ack: got %b, expected 00001", in_ack); end
    tests++; if (sb.size() != 0)      begin fails++; $display("FAIL wrap_pending_grants: got %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    reset   = 1'b1;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
